// File: rtl/my_oc7_input_pkg.sv
// Shared constants for the 7-input ones counter.
package my_oc7_input_pkg;

  localparam int NUM_INPUTS = 7;
  localparam int COUNT_W    = 3;

  typedef logic [NUM_INPUTS-1:0] in_vec_t;
  typedef logic [COUNT_W-1:0]    count_t;

endpackage : my_oc7_input_pkg

// File: rtl/my_oc7_input_full_adder.sv
// One-bit full adder; the building block of the 7:3 compressor.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ cin;
  assign co = (x & y) | (x & cin) | (y & cin);

endmodule : full_adder

// File: rtl/my_oc7_input.sv
// Registered count of ones across seven single-bit inputs (7:3 compressor + one flop stage).
module my_oc7_input
  import my_oc7_input_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic e,
  input  logic f,
  input  logic g,
  output logic w6,
  output logic w7,
  output logic w5
);

  logic   w_s1, w_co1;
  logic   w_s2, w_co2;
  logic   w_s3, w_co3;
  logic   w_s4, w_co4;
  count_t w_cnt;
  count_t r_cnt;

  // Weight-1 column: two first-level adders, then fold in g.
  full_adder u_fa1 (.x(a),    .y(b),    .cin(c), .s(w_s1), .co(w_co1));
  full_adder u_fa2 (.x(d),    .y(e),    .cin(f), .s(w_s2), .co(w_co2));
  full_adder u_fa3 (.x(w_s1), .y(w_s2), .cin(g), .s(w_s3), .co(w_co3));

  // Weight-2 column: three carries compress to the weight-2 and weight-4 bits.
  full_adder u_fa4 (.x(w_co1), .y(w_co2), .cin(w_co3), .s(w_s4), .co(w_co4));

  assign w_cnt = {w_co4, w_s4, w_s3};

  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= w_cnt;
  end

  assign w7 = r_cnt[2];
  assign w6 = r_cnt[1];
  assign w5 = r_cnt[0];

endmodule : my_oc7_input

// File: tb/tb_my_oc7_input.sv
// Randomized and directed checks of my_oc7_input against a popcount model.
module tb_my_oc7_input;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a, b, c, d, e, f, g;
  logic w6, w7, w5;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  my_oc7_input dut (
    .clk(clk), .rst(rst),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .w6(w6), .w7(w7), .w5(w5)
  );

  function automatic logic [2:0] ref_count(input logic [6:0] v, input logic r);
    int n = 0;
    if (r) return 3'd0;
    for (int i = 0; i < 7; i++) if (v[i]) n++;
    return 3'(n);
  endfunction

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [6:0] v);
    {g, f, e, d, c, b, a} = v;
  endtask

  // Drive on the falling edge, check just after the rising edge, then
  // wiggle inputs mid-cycle to confirm the outputs hold until the next edge.
  task automatic step(input string tag, input logic [6:0] v, input logic r, input bit wiggle);
    logic [2:0] exp;
    @(negedge clk);
    set_in(v);
    rst = r;
    exp = ref_count(v, r);
    @(posedge clk);
    #1;
    chk(tag, {w7, w6, w5}, exp);
    if (wiggle) begin
      set_in(7'($urandom));
      rst = 1'($urandom);
      #2;
      chk({tag, "_hold"}, {w7, w6, w5}, exp);
    end
  endtask

  initial begin
    logic [6:0] v;
    set_in(7'h7f);
    rst = 1'b1;

    // Reset with all ones: reset must win.
    step("rst_all1", 7'h7f, 1'b1, 1'b0);
    step("rst_all1b", 7'h7f, 1'b1, 1'b0);
    step("zero", 7'h00, 1'b0, 1'b0);

    // Ramp up one input at a time, several cycles each.
    v = '0;
    for (int i = 0; i < 7; i++) begin
      v[i] = 1'b1;
      for (int k = 0; k < 3; k++) step($sformatf("ramp_up%0d", i), v, 1'b0, k == 1);
    end
    step("all1", 7'h7f, 1'b0, 1'b0);

    // Clear from all ones in order a..g.
    for (int i = 0; i < 7; i++) begin
      v[i] = 1'b0;
      for (int k = 0; k < 2; k++) step($sformatf("ramp_dn%0d", i), v, 1'b0, 1'b0);
    end

    // Mid-run reset with all ones, then release.
    step("pre_rst", 7'h7f, 1'b0, 1'b0);
    step("mid_rst", 7'h7f, 1'b1, 1'b0);
    step("post_rst", 7'h7f, 1'b0, 1'b0);

    // Exhaustive sweep.
    for (int p = 0; p < 128; p++) step($sformatf("sweep_%0d", p), 7'(p), 1'b0, 1'b0);

    // Random inputs with occasional reset and mid-cycle wiggles.
    for (int t = 0; t < 300; t++)
      step($sformatf("rand_%0d", t), 7'($urandom), ($urandom_range(0, 9) == 0), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_my_oc7_input

// File: doc/my_oc7_input.md
MY_OC7_INPUT -- requirements
Module: my_oc7_input

Interface
REQ-001 The block SHALL have no parameters; input count (7) and count width (3) are fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 a  input  1  data bit 0.
REQ-005 b  input  1  data bit 1.
REQ-006 c  input  1  data bit 2.
REQ-007 d  input  1  data bit 3.
REQ-008 e  input  1  data bit 4.
REQ-009 f  input  1  data bit 5.
REQ-010 g  input  1  data bit 6.
REQ-011 w6  output  1  count bit of weight 2.
REQ-012 w7  output  1  count bit of weight 4 (MSB).
REQ-013 w5  output  1  count bit of weight 1 (LSB).
REQ-014 The port order SHALL be clk, rst, a, b, c, d, e, f, g, w6, w7, w5.

Function
REQ-015 The block SHALL compute N = the number of inputs among a..g equal to 1, range 0..7.
REQ-016 The output {w7,w6,w5} SHALL equal N as an unsigned 3-bit binary value.
REQ-017 The outputs SHALL be registered with 1-cycle latency: the value after rising edge k reflects the inputs sampled at edge k.
REQ-018 Input changes between edges SHALL NOT affect the outputs until the next rising edge.
REQ-019 The outputs SHALL be glitch-free, driven directly from flip-flops.
REQ-020 The count SHALL be exact for all 128 input combinations, with no saturation or wrap needed; N=7 yields 111.
REQ-021 Inputs at X/Z are outside the contract; no X-propagation behaviour is required.

Reset
REQ-022 While rst=1 at a rising edge, w7, w6 and w5 SHALL all become 0, regardless of a..g.
REQ-023 Reset SHALL take priority over any input value, including all-ones.
REQ-024 On the first rising edge with rst=0, the outputs SHALL load the count of the inputs at that edge.
REQ-025 Asserting reset mid-operation SHALL clear the outputs on that edge; no other state exists.

Structure
REQ-026 A shared package SHALL hold the constants NUM_INPUTS=7 and COUNT_W=3.
REQ-027 The combinational counter SHALL be a 7:3 compressor built from exactly four instances of one sub-module, full_adder (inputs x, y, cin; outputs s, co).
REQ-028 Counter wiring:
- FA1(a,b,c) and FA2(d,e,f) produce the weight-1 partial sums.
- FA3(s1,s2,g) produces the final LSB and a weight-2 carry.
- FA4(co1,co2,co3) produces the weight-2 bit and the weight-4 bit.
REQ-029 A single output register stage SHALL follow the counter; there SHALL be no input register stage.

Verification
REQ-030 Reset, then all inputs 0 -> {w7,w6,w5}=000 after the next edge.
REQ-031 Set a=1, then b=1, then c=1, one input per several cycles -> outputs 001, 010, 011, each one edge after the input change.
REQ-032 Set d..g to 1 in sequence -> outputs 100, 101, 110, 111; all seven inputs 1 -> 111.
REQ-033 Clear a, then b..g in sequence from all-ones -> outputs 110, 101, 100, 011, 010, 001, 000.
REQ-034 All inputs 1 with rst=1 at an edge -> 000; rst released -> 111 on the following edge.
REQ-035 Exhaustive check of all 128 input patterns against a popcount model, one cycle apart -> zero mismatches.
